// File: rtl/sequenciador_reproducao.sv
// sequenciador_reproducao: plays the stored note sequence, addresses 0..limite in order.
// Each address gets one cycle of memory access, NOTE_CYCLES cycles of sound, GAP_CYCLES of silence.
// Build macro SEQ_LOOP_EN adds input repetir, which restarts the sequence instead of finishing.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// OCIOSO   | idle, waiting for iniciar; address bus parked at 0
// ENDERECA | address presented, waiting one cycle for the memory word
// TOCA     | note code and LEDs driven for NOTE_CYCLES cycles
// PAUSA    | silence for GAP_CYCLES cycles, then next address or finish
// FIM      | one-cycle pronto pulse, then back to idle
module sequenciador_reproducao #(
   parameter int NOTE_CYCLES = 25_000_000,
   parameter int GAP_CYCLES  = 5_000_000,
   parameter int ADDR_W      = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              abortar,
`ifdef SEQ_LOOP_EN
   input  logic              repetir,
`endif
   input  logic [ADDR_W-1:0] limite,
   input  logic [6:0]        dado_memoria,
   output logic [ADDR_W-1:0] endereco,
   output logic [2:0]        arduino_out,
   output logic [6:0]        leds,
   output logic              ocupado,
   output logic              pronto
);

   localparam int CNT_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      OCIOSO,
      ENDERECA,
      TOCA,
      PAUSA,
      FIM
   } estado_t;

   estado_t           estado, nxt_estado;
   logic [CNT_W-1:0]  cnt, nxt_cnt;
   logic [ADDR_W-1:0] limite_reg, nxt_limite_reg;
   logic [ADDR_W-1:0] nxt_endereco;
   logic [2:0]        nxt_arduino_out;
   logic [6:0]        nxt_leds;
   logic              nxt_ocupado;
   logic              nxt_pronto;

   // Lowest set bit wins when the memory word carries more than one note.
   function automatic logic [2:0] codifica(input logic [6:0] palavra);
      logic [2:0] codigo;
      codigo = 3'd0;
      for (int i = 6; i >= 0; i--) begin
         if (palavra[i]) codigo = 3'(i + 1);
      end
      return codigo;
   endfunction

   // State, timer and every output are registered together.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado      <= OCIOSO;
         cnt         <= '0;
         limite_reg  <= '0;
         endereco    <= '0;
         arduino_out <= '0;
         leds        <= '0;
         ocupado     <= 1'b0;
         pronto      <= 1'b0;
      end else begin
         estado      <= nxt_estado;
         cnt         <= nxt_cnt;
         limite_reg  <= nxt_limite_reg;
         endereco    <= nxt_endereco;
         arduino_out <= nxt_arduino_out;
         leds        <= nxt_leds;
         ocupado     <= nxt_ocupado;
         pronto      <= nxt_pronto;
      end
   end

   // Next-state and next-output decode; abortar overrides every state.
   always_comb begin
      nxt_estado      = estado;
      nxt_cnt         = cnt;
      nxt_limite_reg  = limite_reg;
      nxt_endereco    = endereco;
      nxt_arduino_out = arduino_out;
      nxt_leds        = leds;
      nxt_pronto      = 1'b0;

      if (abortar) begin
         nxt_estado      = OCIOSO;
         nxt_cnt         = '0;
         nxt_endereco    = '0;
         nxt_arduino_out = '0;
         nxt_leds        = '0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (iniciar) begin
                  nxt_estado     = ENDERECA;
                  nxt_limite_reg = limite;
                  nxt_endereco   = '0;
               end
            end
            ENDERECA: begin
               nxt_estado      = TOCA;
               nxt_arduino_out = codifica(dado_memoria);
               nxt_leds        = dado_memoria;
               nxt_cnt         = NOTE_LOAD;
            end
            TOCA: begin
               if (cnt == '0) begin
                  nxt_estado      = PAUSA;
                  nxt_arduino_out = '0;
                  nxt_leds        = '0;
                  nxt_cnt         = GAP_LOAD;
               end else begin
                  nxt_cnt = cnt - CNT_W'(1);
               end
            end
            PAUSA: begin
               if (cnt != '0) begin
                  nxt_cnt = cnt - CNT_W'(1);
               end else if (endereco == limite_reg) begin
`ifdef SEQ_LOOP_EN
                  if (repetir) begin
                     nxt_estado   = ENDERECA;
                     nxt_endereco = '0;
                  end else begin
                     nxt_estado = FIM;
                     nxt_pronto = 1'b1;
                  end
`else
                  nxt_estado = FIM;
                  nxt_pronto = 1'b1;
`endif
               end else begin
                  nxt_estado   = ENDERECA;
                  nxt_endereco = endereco + ADDR_W'(1);
               end
            end
            FIM: begin
               nxt_estado   = OCIOSO;
               nxt_endereco = '0;
            end
            default: begin
               nxt_estado      = OCIOSO;
               nxt_cnt         = '0;
               nxt_endereco    = '0;
               nxt_arduino_out = '0;
               nxt_leds        = '0;
            end
         endcase
      end

      nxt_ocupado = (nxt_estado != OCIOSO);
   end

endmodule

// File: tb/tb_sequenciador_reproducao.sv
// Scoreboard bench for sequenciador_reproducao: a stimulus process builds the expected
// per-cycle output trace from the playback rules and queues it; a monitor pops and compares.
module tb_sequenciador_reproducao;

   localparam int NOTE_CYCLES = 4;
   localparam int GAP_CYCLES  = 2;
   localparam int ADDR_W      = 4;
   localparam int SLOT        = 1 + NOTE_CYCLES + GAP_CYCLES;

   typedef struct packed {
      logic [2:0]        code;
      logic [6:0]        leds;
      logic [ADDR_W-1:0] addr;
      logic              ocup;
      logic              pronto;
   } exp_t;

   logic              clock = 1'b0;
   logic              reset;
   logic              iniciar;
   logic              abortar;
`ifdef SEQ_LOOP_EN
   logic              repetir;
`endif
   logic [ADDR_W-1:0] limite;
   logic [6:0]        dado_memoria;
   logic [ADDR_W-1:0] endereco;
   logic [2:0]        arduino_out;
   logic [6:0]        leds;
   logic              ocupado;
   logic              pronto;

   logic [6:0] mem [0:15];
   exp_t exp_q[$];
   exp_t plan_q[$];
   exp_t obs, e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   sequenciador_reproducao #(
      .NOTE_CYCLES(NOTE_CYCLES),
      .GAP_CYCLES (GAP_CYCLES),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .iniciar     (iniciar),
      .abortar     (abortar),
`ifdef SEQ_LOOP_EN
      .repetir     (repetir),
`endif
      .limite      (limite),
      .dado_memoria(dado_memoria),
      .endereco    (endereco),
      .arduino_out (arduino_out),
      .leds        (leds),
      .ocupado     (ocupado),
      .pronto      (pronto)
   );

   always #5 clock = ~clock;

   // Memory answers for the address currently on the bus.
   assign dado_memoria = mem[endereco];

   function automatic exp_t mk(input int code, input logic [6:0] w, input int addr,
                               input logic ocup, input logic pr);
      exp_t r;
      r.code   = 3'(code);
      r.leds   = w;
      r.addr   = ADDR_W'(addr);
      r.ocup   = ocup;
      r.pronto = pr;
      return r;
   endfunction

   // Note number is one plus the position of the lowest set bit.
   function automatic int note_of(input logic [6:0] w);
      int v;
      v = int'(w);
      if (v == 0) return 0;
      return $clog2(v & -v) + 1;
   endfunction

   function automatic void build_plan(input int lim, input int passes);
      plan_q.delete();
      for (int p = 0; p < passes; p++) begin
         for (int a = 0; a <= lim; a++) begin
            plan_q.push_back(mk(0, 7'd0, a, 1'b1, 1'b0));
            for (int k = 0; k < NOTE_CYCLES; k++)
               plan_q.push_back(mk(note_of(mem[a]), mem[a], a, 1'b1, 1'b0));
            for (int k = 0; k < GAP_CYCLES; k++)
               plan_q.push_back(mk(0, 7'd0, a, 1'b1, 1'b0));
         end
      end
      plan_q.push_back(mk(0, 7'd0, lim, 1'b1, 1'b1));
   endfunction

   // Monitor: one expected entry per clock cycle while the scoreboard holds entries.
   always @(negedge clock) begin
      cyc <= cyc + 1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         obs.code   = arduino_out;
         obs.leds   = leds;
         obs.addr   = endereco;
         obs.ocup   = ocupado;
         obs.pronto = pronto;
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL trace t=%0t got ard=%0d leds=%b end=%0d ocup=%b pronto=%b want ard=%0d leds=%b end=%0d ocup=%b pronto=%b",
                     $time, obs.code, obs.leds, obs.addr, obs.ocup, obs.pronto,
                     e.code, e.leds, e.addr, e.ocup, e.pronto);
         end
      end
   end

   task automatic wait_drain();
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clock);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout left=%0d want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // One sequence: abort_cyc / rst_cyc / ini2 / rep_drop are cycle numbers after the start edge, 0 = unused.
   task automatic run(input int lim, input int passes, input int abort_cyc, input int rst_cyc,
                      input int ini2, input int rep_drop);
      int busy, cut;
      build_plan(lim, passes);
      busy = plan_q.size();
      cut  = busy + 1;
      if (abort_cyc > 0) cut = abort_cyc;
      if (rst_cyc > 0) cut = rst_cyc - 1;
      @(posedge clock);
      #1;
      limite  = ADDR_W'(lim);
      iniciar = 1'b1;
`ifdef SEQ_LOOP_EN
      repetir = (passes > 1);
`endif
      @(posedge clock);
      for (int i = 0; i < busy + 3; i++)
         exp_q.push_back((i < cut && i < busy) ? plan_q[i] : mk(0, 7'd0, 0, 1'b0, 1'b0));
      #1;
      iniciar = 1'b0;
      limite  = ADDR_W'($urandom);
      for (int c = 1; c <= busy + 3; c++) begin
         abortar = (c == abort_cyc);
         iniciar = (c == ini2) && (c <= busy) && (c <= cut);
         if (ini2 == c) limite = ADDR_W'($urandom);
         if (rst_cyc > 0 && c == rst_cyc + 1) reset = 1'b1;
`ifdef SEQ_LOOP_EN
         if (c == rep_drop) repetir = 1'b0;
`endif
         if (c == rst_cyc) begin
            #1;
            reset = 1'b0;
         end
         @(posedge clock);
         #1;
      end
      abortar = 1'b0;
      iniciar = 1'b0;
      reset   = 1'b1;
      if (rep_drop < 0) $display("note: negative rep_drop ignored");
      wait_drain();
   endtask

   task automatic rand_mem();
      for (int a = 0; a < 16; a++) begin
         case ($urandom_range(0, 3))
            0:       mem[a] = 7'd0;
            1:       mem[a] = 7'(1 << $urandom_range(0, 6));
            default: mem[a] = 7'($urandom);
         endcase
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int lim, busy, ab, rs, i2;
      reset   = 1'b0;
      iniciar = 1'b0;
      abortar = 1'b0;
      limite  = '0;
`ifdef SEQ_LOOP_EN
      repetir = 1'b0;
`endif
      for (int a = 0; a < 16; a++) mem[a] = 7'd0;

      // reset values, during and just after reset
      @(posedge clock);
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, 7'd0, 0, 1'b0, 1'b0));
      @(posedge clock);
      #1 reset = 1'b1;
      wait_drain();

      // directed: three notes 1,3,7 then pronto in cycle 22
      mem[0] = 7'b0000001;
      mem[1] = 7'b0000100;
      mem[2] = 7'b1000000;
      run(2, 1, 0, 0, 0, 0);
      // same sequence, second iniciar at 5 ignored, abort at 10
      run(2, 1, 10, 0, 5, 0);
      // reset in cycle 3, then a clean restart from address 0
      run(2, 1, 0, 3, 0, 0);
      run(2, 1, 0, 0, 0, 0);

      // silent slot and multi-bit word
      mem[0] = 7'b0000000;
      run(0, 1, 0, 0, 0, 0);
      mem[0] = 7'b0010010;
      run(0, 1, 0, 0, 0, 0);

      // iniciar and abortar together: stay idle
      @(posedge clock);
      #1;
      iniciar = 1'b1;
      abortar = 1'b1;
      @(posedge clock);
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, 7'd0, 0, 1'b0, 1'b0));
      #1;
      iniciar = 1'b0;
      abortar = 1'b0;
      wait_drain();

      // full address range, no wrap
      rand_mem();
      run(15, 1, 0, 0, 0, 0);

      // randomized sequences with optional abort, reset and stray iniciar
      for (int t = 0; t < 10; t++) begin
         rand_mem();
         lim  = $urandom_range(0, 5);
         busy = (lim + 1) * SLOT + 1;
         ab   = 0;
         rs   = 0;
         case ($urandom_range(0, 3))
            0: ab = $urandom_range(1, busy);
            1: rs = $urandom_range(1, busy);
            default: ;
         endcase
         i2 = $urandom_range(2, busy);
         run(lim, 1, ab, rs, i2, 0);
      end

`ifdef SEQ_LOOP_EN
      // looping: three passes over addresses 0..1, repetir dropped during the third
      rand_mem();
      run(1, 3, 0, 0, 0, 2 * 2 * SLOT + 2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
